// File: rtl/spi_duty_sweep_sequencer.sv
// rtl/spi_duty_sweep_sequencer.sv - stepped duty-code sweep driving an SPI master launch/data pair, paced by its CS.
module spi_duty_sweep_sequencer #(
  parameter int PACK_LENGTH       = 8,
  parameter int STEP              = 15,
  parameter int MAX_VALUE         = 255,
  parameter int SETUP_CYCLES      = 3,
  parameter int HOLD_CYCLES       = 3,
  parameter int GAP_CYCLES        = 128,
  parameter int WRAP_PAUSE_CYCLES = 1000,
  parameter int LAUNCH_TIMEOUT    = 4096
) (
  input  logic                   IN_CLOCK,
  input  logic                   IN_RESET,
  input  logic                   IN_ENABLE,
  input  logic                   IN_CS,
  output logic [PACK_LENGTH-1:0] OUT_DATA,
  output logic                   OUT_LAUNCH,
  output logic                   OUT_FRAME_DONE,
  output logic                   OUT_TIMEOUT,
  output logic [15:0]            OUT_FRAME_COUNT
);

  localparam int PAUSE_CYCLES = GAP_CYCLES + WRAP_PAUSE_CYCLES;
  localparam int TERM_A = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int TERM_B = (PAUSE_CYCLES > LAUNCH_TIMEOUT) ? PAUSE_CYCLES : LAUNCH_TIMEOUT;
  localparam int TERM_MAX = (TERM_A > TERM_B) ? TERM_A : TERM_B;
  localparam int CNT_W = $clog2(TERM_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST   = CNT_W'(PAUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [PACK_LENGTH:0] STEP_EXT = (PACK_LENGTH + 1)'(STEP);
  localparam logic [PACK_LENGTH:0] MAX_EXT  = (PACK_LENGTH + 1)'(MAX_VALUE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LAUNCH,
    ST_HOLD,
    ST_WAIT_DONE,
    ST_GAP,
    ST_WRAP_PAUSE
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [PACK_LENGTH-1:0] code;
  logic                   prev_cs;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   frame_end;
  logic [PACK_LENGTH:0]   next_code;
  logic                   wrap;

  assign cs_fall   = prev_cs & ~IN_CS;
  assign cs_rise   = ~prev_cs & IN_CS;
  // A frame completes on CS rising either after the hold or still inside it.
  assign frame_end = cs_rise & ((state == ST_HOLD) | (state == ST_WAIT_DONE));
  // One extra bit so an overflowing step is seen as larger than MAX_VALUE.
  assign next_code = {1'b0, code} + STEP_EXT;
  assign wrap      = next_code > MAX_EXT;

  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      code            <= '0;
      prev_cs         <= 1'b1;
      OUT_DATA        <= '0;
      OUT_LAUNCH      <= 1'b0;
      OUT_FRAME_DONE  <= 1'b0;
      OUT_TIMEOUT     <= 1'b0;
      OUT_FRAME_COUNT <= '0;
    end else begin
      prev_cs        <= IN_CS;
      OUT_FRAME_DONE <= 1'b0;
      cnt            <= cnt + CNT_W'(1);
      if (frame_end) begin
        cnt             <= '0;
        OUT_LAUNCH      <= 1'b0;
        OUT_FRAME_DONE  <= 1'b1;
        OUT_FRAME_COUNT <= OUT_FRAME_COUNT + 16'd1;
        code            <= wrap ? '0 : next_code[PACK_LENGTH-1:0];
        state           <= wrap ? ST_WRAP_PAUSE : ST_GAP;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt        <= '0;
            OUT_LAUNCH <= 1'b0;
            if (IN_ENABLE && IN_CS) begin
              OUT_DATA <= code;
              state    <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (cnt == SETUP_LAST) begin
              cnt        <= '0;
              OUT_LAUNCH <= 1'b1;
              state      <= ST_LAUNCH;
            end
          end
          ST_LAUNCH: begin
            if (cs_fall) begin
              cnt   <= '0;
              state <= ST_HOLD;
            end else if (cnt == TIMEOUT_LAST) begin
              // Code is left untouched so the same word is retried.
              cnt         <= '0;
              OUT_LAUNCH  <= 1'b0;
              OUT_TIMEOUT <= 1'b1;
              state       <= ST_GAP;
            end
          end
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              cnt        <= '0;
              OUT_LAUNCH <= 1'b0;
              state      <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: cnt <= '0;
          ST_GAP: begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end
          end
          ST_WRAP_PAUSE: begin
            if (cnt == PAUSE_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_duty_sweep_sequencer.sv
// tb/tb_spi_duty_sweep_sequencer.sv - directed bench for spi_duty_sweep_sequencer with a model SPI master.
module tb_spi_duty_sweep_sequencer;

  logic        clk;
  logic        rst, en, cs;
  logic [7:0]  data;
  logic        launch, done, tmo;
  logic [15:0] fcount;
  logic        rst2, en2, cs2;
  logic [7:0]  data2;
  logic        launch2, done2, tmo2;
  logic [15:0] fcount2;
  logic        master_en;
  int          checks;
  int          fails;

  spi_duty_sweep_sequencer dut (
    .IN_CLOCK(clk), .IN_RESET(rst), .IN_ENABLE(en), .IN_CS(cs),
    .OUT_DATA(data), .OUT_LAUNCH(launch), .OUT_FRAME_DONE(done),
    .OUT_TIMEOUT(tmo), .OUT_FRAME_COUNT(fcount)
  );

  spi_duty_sweep_sequencer #(.STEP(100)) dut_step100 (
    .IN_CLOCK(clk), .IN_RESET(rst2), .IN_ENABLE(en2), .IN_CS(cs2),
    .OUT_DATA(data2), .OUT_LAUNCH(launch2), .OUT_FRAME_DONE(done2),
    .OUT_TIMEOUT(tmo2), .OUT_FRAME_COUNT(fcount2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model master: CS low 2 cycles after seeing launch, high again 40 cycles later.
  initial begin
    cs = 1'b1;
    forever begin
      @(negedge clk);
      if (master_en && launch && cs) begin
        repeat (2) @(negedge clk);
        cs = 1'b0;
        repeat (40) @(negedge clk);
        cs = 1'b1;
      end
    end
  end

  initial begin
    cs2 = 1'b1;
    forever begin
      @(negedge clk);
      if (launch2 && cs2) begin
        repeat (2) @(negedge clk);
        cs2 = 1'b0;
        repeat (40) @(negedge clk);
        cs2 = 1'b1;
      end
    end
  end

  // sel: 0 launch high, 1 launch low, 2 done, 3 cs low, 4 launch2 high, 5 done2
  task automatic wait_for(input int sel, input int limit, output int n, output bit ok);
    logic v;
    n  = 0;
    ok = 1'b0;
    while (n < limit) begin
      @(posedge clk);
      #1;
      n++;
      case (sel)
        0:       v = launch;
        1:       v = ~launch;
        2:       v = done;
        3:       v = ~cs;
        4:       v = launch2;
        5:       v = done2;
        default: v = 1'b0;
      endcase
      if (v === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (50) @(posedge clk);
    for (int i = 0; i < 100 && cs !== 1'b1; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (data !== 8'd0) begin fails++; $display("FAIL reset_data: got %0d expected 0", data); end
    if (launch !== 1'b0) begin fails++; $display("FAIL reset_launch: got %b expected 0", launch); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    if (tmo !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", tmo); end
    if (fcount !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", fcount); end
    do_reset();
  endtask

  task automatic test_first_frame();
    int n;
    bit ok;
    en = 1'b1;
    wait_for(0, 50, n, ok);
    checks += 2;
    if (!ok || n != 4) begin fails++; $display("FAIL launch_rise_delay: got %0d edges expected 4", n); end
    if (data !== 8'd0) begin fails++; $display("FAIL first_data: got %0d expected 0", data); end
    wait_for(3, 50, n, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL cs_fall_seen: got none expected cs low"); end
    wait_for(1, 50, n, ok);
    checks++;
    if (!ok || n != 3) begin fails++; $display("FAIL launch_fall_delay: got %0d edges expected 3", n); end
    wait_for(2, 100, n, ok);
    checks += 3;
    if (!ok) begin fails++; $display("FAIL frame_done_seen: got none expected pulse"); end
    if (cs !== 1'b1) begin fails++; $display("FAIL done_at_cs_rise: got cs %b expected 1", cs); end
    if (fcount !== 16'd1) begin fails++; $display("FAIL first_count: got %0d expected 1", fcount); end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_full_sweep();
    int n;
    bit ok;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      wait_for(0, 2000, n, ok);
      checks++;
      if (!ok || data !== 8'(k * 15)) begin
        fails++;
        $display("FAIL sweep_code_%0d: got %0d expected %0d", k, data, k * 15);
      end
      if (k == 1) begin
        checks++;
        if (n != 132) begin fails++; $display("FAIL normal_gap: got %0d edges expected 132", n); end
      end
      wait_for(2, 200, n, ok);
    end
    checks++;
    if (fcount !== 16'd18) begin fails++; $display("FAIL sweep_count: got %0d expected 18", fcount); end
    wait_for(0, 2000, n, ok);
    checks += 2;
    if (!ok || n != 1132) begin fails++; $display("FAIL wrap_gap: got %0d edges expected 1132", n); end
    if (data !== 8'd0) begin fails++; $display("FAIL wrap_code: got %0d expected 0", data); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    en = 1'b1;
    wait_for(0, 50, n, ok);
    wait_for(2, 200, n, ok);
    master_en = 1'b0;
    wait_for(0, 300, n, ok);
    checks++;
    if (!ok || data !== 8'd15) begin fails++; $display("FAIL timeout_code: got %0d expected 15", data); end
    wait_for(1, 5000, n, ok);
    checks += 3;
    if (!ok || n != 4096) begin fails++; $display("FAIL timeout_length: got %0d edges expected 4096", n); end
    if (tmo !== 1'b1) begin fails++; $display("FAIL timeout_flag: got %b expected 1", tmo); end
    if (fcount !== 16'd1) begin fails++; $display("FAIL timeout_count: got %0d expected 1", fcount); end
    master_en = 1'b1;
    wait_for(0, 300, n, ok);
    checks++;
    if (!ok || data !== 8'd15) begin fails++; $display("FAIL retry_code: got %0d expected 15", data); end
    wait_for(2, 200, n, ok);
    checks += 2;
    if (!ok || fcount !== 16'd2) begin fails++; $display("FAIL retry_count: got %0d expected 2", fcount); end
    if (tmo !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b expected 1", tmo); end
  endtask

  task automatic test_enable();
    int n;
    bit ok;
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_for(0, 300, n, ok);
      wait_for(2, 200, n, ok);
    end
    en = 1'b0;
    wait_for(0, 400, n, ok);
    checks++;
    if (ok) begin fails++; $display("FAIL disabled_launch: got launch after %0d edges expected none", n); end
    en = 1'b1;
    wait_for(0, 50, n, ok);
    checks++;
    if (!ok || data !== 8'd45) begin fails++; $display("FAIL resume_code: got %0d expected 45", data); end
  endtask

  task automatic test_reset_in_hold();
    int n;
    bit ok;
    do_reset();
    en = 1'b1;
    wait_for(0, 50, n, ok);
    wait_for(2, 200, n, ok);
    wait_for(0, 300, n, ok);
    wait_for(3, 50, n, ok);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks += 3;
    if (launch !== 1'b0) begin fails++; $display("FAIL hold_reset_launch: got %b expected 0", launch); end
    if (fcount !== 16'd0) begin fails++; $display("FAIL hold_reset_count: got %0d expected 0", fcount); end
    if (data !== 8'd0) begin fails++; $display("FAIL hold_reset_data: got %0d expected 0", data); end
    wait_for(0, 200, n, ok);
    checks++;
    if (!ok || data !== 8'd0) begin fails++; $display("FAIL post_reset_code: got %0d expected 0", data); end
    wait_for(2, 200, n, ok);
    checks++;
    if (!ok || fcount !== 16'd1) begin fails++; $display("FAIL post_reset_count: got %0d expected 1", fcount); end
  endtask

  task automatic test_step100();
    int n;
    bit ok;
    int exp_codes[4];
    exp_codes = '{0, 100, 200, 0};
    rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;
    en2  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_for(4, 2000, n, ok);
      checks++;
      if (!ok || data2 !== 8'(exp_codes[k])) begin
        fails++;
        $display("FAIL step100_code_%0d: got %0d expected %0d", k, data2, exp_codes[k]);
      end
      if (k == 3) begin
        checks++;
        if (n != 1132) begin fails++; $display("FAIL step100_wrap_gap: got %0d edges expected 1132", n); end
      end else begin
        wait_for(5, 200, n, ok);
      end
    end
    checks++;
    if (fcount2 !== 16'd3) begin fails++; $display("FAIL step100_count: got %0d expected 3", fcount2); end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    rst2      = 1'b1;
    en        = 1'b0;
    en2       = 1'b0;
    master_en = 1'b1;
    test_reset();
    test_first_frame();
    test_full_sweep();
    test_timeout();
    test_enable();
    test_reset_in_hold();
    test_step100();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
